gctr_ctrl: RTL and testbench

- Sequences one complete GCTR operation (NIST SP 800-38D §6.5) over a message of arbitrary bit length.
- Issues successive counter blocks (inc32) to the shared pipelined AES core and pairs each returned keystream block with the matching input data block.
- XORs each pair, masks the final partial block, and streams results out with ready/valid flow control.
- Sits between the GCM top-level sequencer and the AES core; replaces per-block manual driving of the counter datapath.

---
 rtl/gcm_pkg.sv | 28 ++
 rtl/gctr_fifo.sv | 68 ++++++
 rtl/gctr_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_gctr_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared definitions for the GCM counter-mode datapath.
//   BLOCK_W : cipher block width in bits
//   INC_S   : number of right-most counter bits that increment
//   state_t : gctr_ctrl sequencer states
//   inc_s() : increments the low s bits of a block modulo 2^s, upper bits held
package gcm_pkg;

  localparam int BLOCK_W = 128;
  localparam int INC_S   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The carry out of the low field is discarded by the mask, so wrap is silent.
  function automatic logic [BLOCK_W-1:0] inc_s(input logic [BLOCK_W-1:0] x,
                                               input int s);
    logic [BLOCK_W-1:0] lo_mask;
    logic [BLOCK_W-1:0] sum;
    lo_mask = {BLOCK_W{1'b1}} >> (BLOCK_W - s);
    sum     = x + BLOCK_W'(1);
    return (x & ~lo_mask) | (sum & lo_mask);
  endfunction

endpackage

// File: rtl/gctr_fifo.sv
// gctr_fifo: synchronous first-word-fall-through FIFO with occupancy count.
//   clk, rst : clock, asynchronous active-low reset (pointers/count only)
//   push     : write wdata when not full (or when a pop frees a slot)
//   pop      : advance the head when not empty
//   rdata    : current head entry
//   count    : number of stored entries (0..DEPTH)
module gctr_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          empty;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= next_ptr(wp);
      if (pop_ok)  rp <= next_ptr(rp);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

  always @(posedge clk) begin
    if (rst) begin
      ovf_chk: assert (!(push && !push_ok));
      udf_chk: assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/gctr_ctrl.sv
// gctr_ctrl: sequences one GCTR pass over a message of arbitrary bit length.
//   Control : clk, rst (async active-low), start, icb, len_bits, busy, done, err
//   Input   : din/din_valid/din_ready  - message blocks, MSB-aligned
//   AES     : aes_pt/aes_valid_in issue counter blocks; aes_ct/aes_valid_out
//             return keystream in issue order (pipeline never stalls)
//   Output  : dout/dout_valid/dout_ready, dout_last, dout_nbits (1..128)
// Each accepted din block is parked in a data FIFO while its counter block is
// in the AES pipeline; the returning keystream is XORed with the head and the
// result queued. Issue is credit-limited so the result FIFO cannot overflow.
module gctr_ctrl
  import gcm_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int S          = 32,
  parameter int LEN_W      = 39,
  parameter int DEPTH      = 16,
  parameter int AES_LAT    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] icb,
  input  logic [LEN_W-1:0]      len_bits,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] aes_pt,
  output logic                  aes_valid_in,
  input  logic [DATA_WIDTH-1:0] aes_ct,
  input  logic                  aes_valid_out,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [7:0]            dout_nbits,
  output logic                  err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = LEN_W - 6;
  localparam int RW = DATA_WIDTH + 1 + 8;

  if (DATA_WIDTH != BLOCK_W) begin : g_bad_width
    $error("gctr_ctrl: DATA_WIDTH must equal BLOCK_W");
  end
  if (S < 1 || S > DATA_WIDTH) begin : g_bad_s
    $error("gctr_ctrl: S out of range");
  end
  if (AES_LAT < 1) begin : g_bad_lat
    $error("gctr_ctrl: AES_LAT must be at least 1");
  end

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] cb;
  logic [NW-1:0]         nblk;
  logic [NW-1:0]         issued;
  logic [NW-1:0]         returned;
  logic [7:0]            last_bits;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         dat_count;
  logic [CW-1:0]         res_count;
  logic [CW:0]           credit_used;

  logic                  start_acc;
  logic                  can_issue;
  logic                  issue;
  logic                  ret_ok;
  logic                  stray;
  logic                  res_valid;
  logic                  out_hs;
  logic                  blk_last;
  logic [7:0]            blk_nbits;
  logic [DATA_WIDTH-1:0] dat_head;
  logic [DATA_WIDTH-1:0] xor_blk;
  logic [RW-1:0]         res_wdata;
  logic [RW-1:0]         res_rdata;
  logic                  res_last;
  logic [7:0]            res_nbits;
  logic [DATA_WIDTH-1:0] res_blk;

  // Keeps the top nbits of a block; nbits = 128 shifts the ones away entirely.
  function automatic logic [DATA_WIDTH-1:0] mask_tail(input logic [DATA_WIDTH-1:0] blk,
                                                      input logic [7:0] nbits);
    logic [DATA_WIDTH-1:0] keep;
    keep = ~({DATA_WIDTH{1'b1}} >> nbits);
    return blk & keep;
  endfunction

  assign start_acc   = (state == IDLE) & start;
  assign credit_used = {1'b0, inflight} + {1'b0, res_count};
  assign can_issue   = (state == RUN) & (credit_used < (CW+1)'(DEPTH)) & (issued < nblk);
  assign issue       = can_issue & din_valid;
  assign ret_ok      = aes_valid_out & (inflight != '0);
  // Returns before a new start are leftovers from an aborted run and ignored.
  assign stray       = aes_valid_out & (inflight == '0) & (state != IDLE);
  assign res_valid   = (res_count != '0);
  assign out_hs      = res_valid & dout_ready;

  // Return stage: pair keystream with the parked data block, mask the tail.
  assign blk_last  = (returned == nblk - NW'(1));
  assign blk_nbits = blk_last ? last_bits : 8'd128;
  assign xor_blk   = dat_head ^ aes_ct;
  assign res_wdata = {blk_last, blk_nbits, mask_tail(xor_blk, blk_nbits)};
  assign res_last  = res_rdata[RW-1];
  assign res_nbits = res_rdata[RW-2 -: 8];
  assign res_blk   = res_rdata[DATA_WIDTH-1:0];

  gctr_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_dat_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .wdata (din),
    .pop   (ret_ok),
    .rdata (dat_head),
    .count (dat_count)
  );

  gctr_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_ok),
    .wdata (res_wdata),
    .pop   (out_hs),
    .rdata (res_rdata),
    .count (res_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len_bits == '0) ? DONE : RUN;
      RUN:     if (issue && (issued + NW'(1) == nblk)) state_nx = DRAIN;
      DRAIN:   if (out_hs && res_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == RUN) || (state == DRAIN);
    done         = (state == DONE);
    din_ready    = can_issue;
    aes_valid_in = issue;
    aes_pt       = issue ? cb : '0;
    dout_valid   = res_valid;
    dout         = res_valid ? res_blk : '0;
    dout_last    = res_valid & res_last;
    dout_nbits   = res_valid ? res_nbits : 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nblk      <= '0;
      last_bits <= '0;
      issued    <= '0;
      returned  <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else if (start_acc) begin
      nblk      <= NW'(len_bits[LEN_W-1:7]) + NW'(|len_bits[6:0]);
      last_bits <= (len_bits[6:0] == 7'd0) ? 8'd128 : {1'b0, len_bits[6:0]};
      issued    <= '0;
      returned  <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      if (issue)  issued   <= issued + NW'(1);
      if (ret_ok) returned <= returned + NW'(1);
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (stray) err <= 1'b1;
    end
  end

  // Counter block is pure data: loaded on start, stepped after every issue.
  always_ff @(posedge clk) begin
    if (start_acc)  cb <= icb;
    else if (issue) cb <= inc_s(cb, S);
  end

  always @(posedge clk) begin
    if (rst) begin
      pair_chk: assert (dat_count == inflight);
    end
  end

endmodule

// File: tb/tb_gctr_ctrl.sv
module tb_gctr_ctrl;

  localparam int AES_LAT = 10;
  localparam int DEPTH   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] icb;
  logic [38:0]  len_bits;
  logic         busy, done;
  logic [127:0] din;
  logic         din_valid, din_ready;
  logic [127:0] aes_pt;
  logic         aes_valid_in;
  logic [127:0] aes_ct;
  logic         aes_valid_out;
  logic [127:0] dout;
  logic         dout_valid, dout_ready, dout_last;
  logic [7:0]   dout_nbits;
  logic         err;
  logic         stray;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  gctr_ctrl #(.DEPTH(DEPTH), .AES_LAT(AES_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .icb(icb), .len_bits(len_bits),
    .busy(busy), .done(done), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .aes_pt(aes_pt), .aes_valid_in(aes_valid_in),
    .aes_ct(aes_ct), .aes_valid_out(aes_valid_out), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .dout_nbits(dout_nbits), .err(err)
  );

  // Stand-in block cipher: any fixed bijection-like scramble of the counter.
  function automatic logic [127:0] ks(input logic [127:0] c);
    logic [31:0] h;
    h = (c[31:0] * 32'h9E3779B1) ^ c[63:32];
    return {c[63:0], c[127:64]} ^ {h, ~h, h ^ 32'h5A5A5A5A, h + 32'h01234567};
  endfunction

  // Fixed-latency cipher pipeline; not reset, so results outlive a DUT reset.
  bit   [AES_LAT-1:0] pv;
  logic [127:0]       pd [AES_LAT];
  always @(posedge clk) begin
    pv    <= {pv[AES_LAT-2:0], aes_valid_in};
    pd[0] <= ks(aes_pt);
    for (int i = 1; i < AES_LAT; i++) pd[i] <= pd[i-1];
  end
  assign aes_valid_out = pv[AES_LAT-1] | stray;
  assign aes_ct        = pd[AES_LAT-1];

  function automatic logic [127:0] keep_top(input logic [127:0] v, input int nb);
    for (int b = 0; b < 128; b++) if (b < 128 - nb) v[b] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pre);
    chk({pre, "_busy"},  128'(busy), 0);
    chk({pre, "_done"},  128'(done), 0);
    chk({pre, "_dinrdy"}, 128'(din_ready), 0);
    chk({pre, "_aesv"},  128'(aes_valid_in), 0);
    chk({pre, "_aespt"}, aes_pt, 0);
    chk({pre, "_doutv"}, 128'(dout_valid), 0);
    chk({pre, "_dout"},  dout, 0);
    chk({pre, "_last"},  128'(dout_last), 0);
    chk({pre, "_nbits"}, 128'(dout_nbits), 0);
    chk({pre, "_err"},   128'(err), 0);
  endtask

  // One GCTR operation against the reference: counter i = icb with the low
  // 32-bit word advanced by i (mod 2^32); output i = din_i ^ E(counter i),
  // truncated to the message length on the final block.
  task automatic run_op(input logic [127:0] icb_v, input int len, input int rdy_hold,
                        input bit full, input bit inj, input int abort_after);
    int nb, lastb, issued, outn, last_hs, first_iss, first_out, cyc, nbx;
    logic [127:0] dins [64];
    logic [127:0] ctrs [64];
    logic [127:0] exps [64];
    nb    = (len + 127) / 128;
    lastb = (nb > 0) ? len - (nb - 1) * 128 : 0;
    for (int i = 0; i < nb; i++) begin
      ctrs[i] = {icb_v[127:32], icb_v[31:0] + 32'(i)};
      dins[i] = {$urandom, $urandom, $urandom, $urandom};
      nbx     = (i == nb - 1) ? lastb : 128;
      exps[i] = keep_top(dins[i] ^ ks(ctrs[i]), nbx);
    end
    @(negedge clk);
    start = 1'b1; icb = icb_v; len_bits = 39'(len);
    din_valid = 1'b0; dout_ready = 1'b0;
    issued = 0; outn = 0; first_iss = -1; first_out = -1;
    last_hs = (nb == 0) ? -1 : 1000000;
    for (cyc = 0; ((nb == 0) ? (cyc <= 3) : (cyc <= last_hs + 1)) && cyc < 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == 2 && nb > 0);
      if (cyc == 2) begin icb = ~icb_v; len_bits = 39'd128; end
      stray = inj && (cyc == 1);
      if (abort_after > 0 && issued == abort_after) begin
        rst = 1'b0; din_valid = 1'b0; stray = 1'b0;
        #1;
        chk_all_zero("abort");
        return;
      end
      din_valid  = (issued < nb) && !(inj && cyc < 4) && (full || $urandom_range(3) != 0);
      din        = (issued < nb) ? dins[issued] : '0;
      dout_ready = (cyc >= rdy_hold) && (full || $urandom_range(3) != 0);
      #1;
      chk("busy", 128'(busy), 128'(nb > 0 && cyc <= last_hs));
      chk("done", 128'(done), 128'(cyc == last_hs + 1));
      chk("issue_strobe", 128'(aes_valid_in), 128'(din_valid && din_ready));
      if (nb == 0) chk("no_dout", 128'(dout_valid), 0);
      if (inj && cyc == 3) chk("err_stray", 128'(err), 1);
      if (rdy_hold > 0 && cyc == rdy_hold) chk("credit_cap", 128'(issued), DEPTH);
      if (din_valid && din_ready) begin
        chk("aes_pt", aes_pt, ctrs[issued]);
        if (first_iss < 0) first_iss = cyc;
        issued++;
        chk("outstanding", 128'(issued - outn <= DEPTH), 1);
      end
      if (dout_valid && first_out < 0) begin
        first_out = cyc;
        chk("latency", 128'(cyc - first_iss), AES_LAT + 1);
      end
      if (dout_valid && dout_ready) begin
        if (outn >= nb) chk("extra_dout", 128'(outn), 128'(nb - 1));
        else begin
          chk("dout", dout, exps[outn]);
          chk("dout_last", 128'(dout_last), 128'(outn == nb - 1));
          chk("dout_nbits", 128'(dout_nbits), (outn == nb - 1) ? 128'(lastb) : 128'd128);
          if (outn == nb - 1) last_hs = cyc;
        end
        outn++;
      end
    end
    stray = 1'b0;
    chk("blocks_out", 128'(outn), 128'(nb));
    chk("issued_total", 128'(issued), 128'(nb));
    chk("err_end", 128'(err), 128'(inj));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; icb = '0; len_bits = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    run_op(128'h1, 384, 0, 1'b1, 1'b0, 0);
    run_op({$urandom, $urandom, $urandom, $urandom}, 200, 0, 1'b0, 1'b0, 0);
    run_op(128'hABCD, 0, 0, 1'b1, 1'b0, 0);
    run_op({96'hCAFEF00D_DEADBEEF_01234567, 32'hFFFFFFFF}, 256, 0, 1'b1, 1'b0, 0);
    run_op({$urandom, $urandom, $urandom, $urandom}, 128 * 32, 40, 1'b1, 1'b0, 0);

    run_op({$urandom, $urandom, $urandom, $urandom}, 128 * 8, 0, 1'b1, 1'b0, 5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("err_after_reset", 128'(err), 0);
    run_op({$urandom, $urandom, $urandom, $urandom}, 128, 0, 1'b1, 1'b1, 0);

    for (int k = 0; k < 3; k++)
      run_op({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 2000), 0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
